// File: rtl/trap_ctrl_if.sv
// CSR exception interface between the commit-stage trap generator and its consumers.
// The master end produces trap requests; the slave end supplies retire/interrupt state.
interface trap_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic              commit_valid;
   logic [63:0]       commit_pc;
   logic              commit_ecall;
   logic              commit_ebreak;
   logic              commit_illegal;
   logic              commit_mret;
   logic              wfi_active;
   logic [63:0]       wfi_pc;
   logic              mstatus_mie;
   logic              mie_mtie;
   logic              mtip;

   logic              exception_flag;
   logic [4:0]        exception_cause;
   logic [63:0]       epc;
   logic              flush;
   logic [CNT_W-1:0]  trap_cnt;
   logic              commit_in_drain;

   modport master (
      input  commit_valid, commit_pc, commit_ecall, commit_ebreak, commit_illegal,
             commit_mret, wfi_active, wfi_pc, mstatus_mie, mie_mtie, mtip,
      output exception_flag, exception_cause, epc, flush, trap_cnt, commit_in_drain
   );

   modport slave (
      output commit_valid, commit_pc, commit_ecall, commit_ebreak, commit_illegal,
             commit_mret, wfi_active, wfi_pc, mstatus_mie, mie_mtie, mtip,
      input  exception_flag, exception_cause, epc, flush, trap_cnt, commit_in_drain
   );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-stage trap request generator: turns retiring exceptions, mret and the machine
// timer interrupt into a one-cycle CSR trap request plus a multi-cycle pipeline flush.
module trap_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter logic [4:0]  CAUSE_MRET   = 5'h1F,
   parameter int unsigned CNT_W        = 16
) (
   input logic         clk,
   input logic         rst,
   trap_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_FIRE,
      S_DRAIN
   } state_t;

   localparam logic [4:0] CAUSE_ILLEGAL = 5'h02;
   localparam logic [4:0] CAUSE_EBREAK  = 5'h03;
   localparam logic [4:0] CAUSE_ECALL   = 5'h0B;
   localparam logic [4:0] CAUSE_MTI     = 5'h17;
   localparam logic [3:0] DRAIN_LEN     = 4'(FLUSH_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        drain_q, drain_d;
   logic              irq_q;
   logic              flag_q;
   logic [4:0]        cause_q;
   logic [63:0]       epc_q;
   logic              flush_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              sticky_q;

   logic              take;
   logic [4:0]        ev_cause;
   logic [63:0]       ev_epc;
   logic              accepting;

   assign accepting = (state_q == S_IDLE) || (state_q == S_ARM);

   // Trap event decode; synchronous exceptions outrank the armed timer interrupt.
   // NOTE: every variable assigned in always_comb gets a default first, otherwise a
   // path that skips the assignment infers a latch.
   always_comb begin
      take     = 1'b0;
      ev_cause = '0;
      ev_epc   = '0;
      if (accepting) begin
         if (bus.commit_valid) begin
            take   = 1'b1;
            ev_epc = bus.commit_pc;
            if (bus.commit_illegal) begin
               ev_cause = CAUSE_ILLEGAL;
            end else if (bus.commit_ebreak) begin
               ev_cause = CAUSE_EBREAK;
            end else if (bus.commit_ecall) begin
               ev_cause = CAUSE_ECALL;
            end else if (bus.commit_mret) begin
               ev_cause = CAUSE_MRET;
            end else if (state_q == S_ARM) begin
               ev_cause = CAUSE_MTI;
               ev_epc   = bus.commit_pc + 64'd4;
            end else begin
               take = 1'b0;
            end
         end else if ((state_q == S_ARM) && bus.wfi_active) begin
            take     = 1'b1;
            ev_cause = CAUSE_MTI;
            ev_epc   = bus.wfi_pc + 64'd4;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               state_d = S_FIRE;
            end else if (irq_q) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (take) begin
               state_d = S_FIRE;
            end else if (!irq_q) begin
               state_d = S_IDLE;
            end
         end
         S_FIRE: begin
            // A single-cycle flush needs no drain phase at all.
            if (DRAIN_LEN == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LEN;
            end
         end
         S_DRAIN: begin
            if (drain_q <= 4'd1) begin
               state_d = S_IDLE;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         drain_q  <= '0;
         irq_q    <= 1'b0;
         flag_q   <= 1'b0;
         cause_q  <= '0;
         epc_q    <= '0;
         flush_q  <= 1'b0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         irq_q   <= bus.mtip & bus.mstatus_mie & bus.mie_mtie;
         flag_q  <= take;
         flush_q <= (state_d == S_FIRE) || (state_d == S_DRAIN);
         if (take) begin
            cause_q <= ev_cause;
            epc_q   <= ev_epc;
            if (ev_cause != CAUSE_MRET) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (!accepting && bus.commit_valid) begin
            sticky_q <= 1'b1;
         end
      end
   end

   assign bus.exception_flag  = flag_q;
   assign bus.exception_cause = cause_q;
   assign bus.epc             = epc_q;
   assign bus.flush           = flush_q;
   assign bus.trap_cnt        = cnt_q;
   assign bus.commit_in_drain = sticky_q;

   a_flag_implies_flush : assert property (@(posedge clk) disable iff (!rst) flag_q |-> flush_q);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a cycle-level reference model checked every cycle
// against two instances (3-cycle flush / 16-bit count and 1-cycle flush / 4-bit count).
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid, commit_ecall, commit_ebreak, commit_illegal, commit_mret;
   logic        wfi_active, mstatus_mie, mie_mtie, mtip;
   logic [63:0] commit_pc, wfi_pc;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   localparam logic [3:0] K_NONE = 4'b0000;
   localparam logic [3:0] K_ILL  = 4'b1000;
   localparam logic [3:0] K_EBR  = 4'b0100;
   localparam logic [3:0] K_ECL  = 4'b0010;
   localparam logic [3:0] K_MRT  = 4'b0001;

   always #5 clk = ~clk;

   trap_ctrl_if #(.CNT_W(16)) bus ();
   trap_ctrl_if #(.CNT_W(4))  bus_s ();

   assign bus.commit_valid     = commit_valid;
   assign bus.commit_pc        = commit_pc;
   assign bus.commit_ecall     = commit_ecall;
   assign bus.commit_ebreak    = commit_ebreak;
   assign bus.commit_illegal   = commit_illegal;
   assign bus.commit_mret      = commit_mret;
   assign bus.wfi_active       = wfi_active;
   assign bus.wfi_pc           = wfi_pc;
   assign bus.mstatus_mie      = mstatus_mie;
   assign bus.mie_mtie         = mie_mtie;
   assign bus.mtip             = mtip;
   assign bus_s.commit_valid   = commit_valid;
   assign bus_s.commit_pc      = commit_pc;
   assign bus_s.commit_ecall   = commit_ecall;
   assign bus_s.commit_ebreak  = commit_ebreak;
   assign bus_s.commit_illegal = commit_illegal;
   assign bus_s.commit_mret    = commit_mret;
   assign bus_s.wfi_active     = wfi_active;
   assign bus_s.wfi_pc         = wfi_pc;
   assign bus_s.mstatus_mie    = mstatus_mie;
   assign bus_s.mie_mtie       = mie_mtie;
   assign bus_s.mtip           = mtip;

   trap_ctrl #(.FLUSH_CYCLES(3), .CAUSE_MRET(5'h1F), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   trap_ctrl #(.FLUSH_CYCLES(1), .CAUSE_MRET(5'h1F), .CNT_W(4)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   // Reference model: "busy" counts remaining flush cycles, "armed" means the timer
   // interrupt was seen pending in the previous idle cycle.
   typedef struct packed {
      logic [3:0]  busy;
      logic        armed;
      logic        irq;
      logic        flag;
      logic [4:0]  cause;
      logic [63:0] epc;
      logic [15:0] cnt;
      logic        sticky;
   } mdl_t;

   mdl_t mm, msm;

   function automatic mdl_t mdl_step(input mdl_t m, input int fc, input int cnt_w);
      mdl_t        n;
      logic        hit;
      logic [4:0]  c;
      logic [63:0] e;
      n   = m;
      hit = 1'b0;
      c   = 5'h00;
      e   = 64'h0;
      if (!rst) return '0;
      n.irq  = mtip & mstatus_mie & mie_mtie;
      n.flag = 1'b0;
      if (m.busy != 4'd0) begin
         if (commit_valid) n.sticky = 1'b1;
         n.busy  = m.busy - 4'd1;
         n.armed = 1'b0;
      end else begin
         if (commit_valid) begin
            hit = 1'b1;
            e   = commit_pc;
            if (commit_illegal)     c = 5'h02;
            else if (commit_ebreak) c = 5'h03;
            else if (commit_ecall)  c = 5'h0B;
            else if (commit_mret)   c = 5'h1F;
            else if (m.armed) begin
               c = 5'h17;
               e = commit_pc + 64'd4;
            end else hit = 1'b0;
         end else if (m.armed && wfi_active) begin
            hit = 1'b1;
            c   = 5'h17;
            e   = wfi_pc + 64'd4;
         end
         if (hit) begin
            n.flag  = 1'b1;
            n.cause = c;
            n.epc   = e;
            n.busy  = 4'(fc);
            n.armed = 1'b0;
            if (c != 5'h1F) n.cnt = 16'((int'(m.cnt) + 1) % (1 << cnt_w));
         end else begin
            n.armed = m.irq;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      mm  <= mdl_step(mm, 3, 16);
      msm <= mdl_step(msm, 1, 4);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("main.flag",   64'(bus.exception_flag),    64'(mm.flag));
         check("main.cause",  64'(bus.exception_cause),   64'(mm.cause));
         check("main.epc",    bus.epc,                    mm.epc);
         check("main.flush",  64'(bus.flush),             64'(mm.busy != 4'd0));
         check("main.cnt",    64'(bus.trap_cnt),          64'(mm.cnt));
         check("main.sticky", 64'(bus.commit_in_drain),   64'(mm.sticky));
         check("s.flag",      64'(bus_s.exception_flag),  64'(msm.flag));
         check("s.cause",     64'(bus_s.exception_cause), 64'(msm.cause));
         check("s.epc",       bus_s.epc,                  msm.epc);
         check("s.flush",     64'(bus_s.flush),           64'(msm.busy != 4'd0));
         check("s.cnt",       64'(bus_s.trap_cnt),        64'(msm.cnt[3:0]));
         check("s.sticky",    64'(bus_s.commit_in_drain), 64'(msm.sticky));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_commit();
      commit_valid   = 1'b0;
      commit_pc      = 64'h0;
      commit_ecall   = 1'b0;
      commit_ebreak  = 1'b0;
      commit_illegal = 1'b0;
      commit_mret    = 1'b0;
   endtask

   // Retire one instruction for a single cycle; returns one cycle after the edge.
   task automatic do_commit(input logic [63:0] pc, input logic [3:0] kind);
      commit_valid = 1'b1;
      commit_pc    = pc;
      {commit_illegal, commit_ebreak, commit_ecall, commit_mret} = kind;
      tick(1);
      clear_commit();
   endtask

   task automatic lit(input string name, input logic [4:0] cause, input logic [63:0] epc,
                      input logic [15:0] cnt);
      check({name, ".flag"},  64'(bus.exception_flag),  64'd1);
      check({name, ".cause"}, 64'(bus.exception_cause), 64'(cause));
      check({name, ".epc"},   bus.epc,                  epc);
      check({name, ".cnt"},   64'(bus.trap_cnt),        64'(cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst         = 1'b0;
      clear_commit();
      wfi_active  = 1'b0;
      wfi_pc      = 64'h0;
      mstatus_mie = 1'b0;
      mie_mtie    = 1'b0;
      mtip        = 1'b0;
      tick(2);
      chk_en = 1'b1;
      check("rst.flag",  64'(bus.exception_flag), 64'd0);
      check("rst.flush", 64'(bus.flush),          64'd0);
      check("rst.cnt",   64'(bus.trap_cnt),       64'd0);
      rst = 1'b1;
      tick(1);

      // ecall, then the full flush window
      do_commit(64'h8000_0010, K_ECL);
      lit("T1", 5'h0B, 64'h8000_0010, 16'd1);
      check("T1.flush0", 64'(bus.flush), 64'd1);
      tick(1);
      check("T1.flag1",  64'(bus.exception_flag), 64'd0);
      check("T1.flush1", 64'(bus.flush), 64'd1);
      tick(1);
      check("T1.flush2", 64'(bus.flush), 64'd1);
      tick(1);
      check("T1.flush3", 64'(bus.flush), 64'd0);
      check("T1.hold",   64'(bus.exception_cause), 64'h0B);

      // timer interrupt taken on a plain commit
      mstatus_mie = 1'b1;
      mie_mtie    = 1'b1;
      mtip        = 1'b1;
      tick(2);
      do_commit(64'h8000_0100, K_NONE);
      mtip = 1'b0;
      lit("T2", 5'h17, 64'h8000_0104, 16'd2);
      tick(4);

      // exception wins over pending interrupt, interrupt taken after drain
      mtip = 1'b1;
      tick(2);
      do_commit(64'h200, K_ILL);
      lit("T3a", 5'h02, 64'h200, 16'd3);
      tick(4);
      do_commit(64'h300, K_NONE);
      mtip = 1'b0;
      lit("T3b", 5'h17, 64'h304, 16'd4);
      tick(4);

      // mret does not count; commit during drain is flagged
      do_commit(64'h400, K_MRT);
      lit("T4", 5'h1F, 64'h400, 16'd4);
      tick(1);
      commit_valid = 1'b1;
      commit_pc    = 64'h404;
      tick(1);
      clear_commit();
      check("T4.sticky", 64'(bus.commit_in_drain), 64'd1);
      check("T4.noflag", 64'(bus.exception_flag),  64'd0);
      tick(2);

      // flags without commit_valid are ignored; priority among flags
      commit_ecall   = 1'b1;
      commit_ebreak  = 1'b1;
      commit_illegal = 1'b1;
      tick(1);
      clear_commit();
      check("nv.flag", 64'(bus.exception_flag), 64'd0);
      do_commit(64'h700, 4'b1110);
      lit("prio.ill", 5'h02, 64'h700, 16'd5);
      tick(3);
      do_commit(64'h800, K_EBR);
      lit("prio.ebr", 5'h03, 64'h800, 16'd6);
      tick(3);
      do_commit(64'h880, 4'b0011);
      lit("prio.ecl", 5'h0B, 64'h880, 16'd7);
      tick(3);

      // interrupt out of wfi
      wfi_active = 1'b1;
      wfi_pc     = 64'h500;
      mtip       = 1'b1;
      tick(2);
      check("T5.pre", 64'(bus.exception_flag), 64'd0);
      tick(1);
      lit("T5", 5'h17, 64'h504, 16'd8);
      wfi_active = 1'b0;
      mtip       = 1'b0;
      tick(4);

      // interrupt withdrawn while armed: next plain commit must not trap
      mtip = 1'b1;
      tick(2);
      mtip = 1'b0;
      tick(2);
      do_commit(64'h600, K_NONE);
      check("T5b.flag", 64'(bus.exception_flag), 64'd0);
      check("T5b.cnt",  64'(bus.trap_cnt),       64'd8);
      tick(1);

      // epc wraps modulo 2^64
      mtip = 1'b1;
      tick(2);
      do_commit(64'hFFFF_FFFF_FFFF_FFFC, K_NONE);
      mtip = 1'b0;
      lit("wrap.epc", 5'h17, 64'h0, 16'd9);
      tick(4);

      // reset in the middle of drain
      do_commit(64'h900, K_ECL);
      tick(1);
      rst = 1'b0;
      tick(1);
      check("T6.flag",   64'(bus.exception_flag),  64'd0);
      check("T6.flush",  64'(bus.flush),           64'd0);
      check("T6.cause",  64'(bus.exception_cause), 64'd0);
      check("T6.epc",    bus.epc,                  64'd0);
      check("T6.cnt",    64'(bus.trap_cnt),        64'd0);
      check("T6.sticky", 64'(bus.commit_in_drain), 64'd0);
      rst = 1'b1;
      tick(1);

      // trap counter wrap on the 4-bit instance
      for (int i = 0; i < 16; i++) begin
         do_commit(64'h1000 + 64'(i * 4), K_ECL);
         if (i == 14) check("cntw.15", 64'(bus_s.trap_cnt), 64'd15);
         tick(3);
      end
      check("cntw.s0",   64'(bus_s.trap_cnt), 64'd0);
      check("cntw.m16",  64'(bus.trap_cnt),   64'd16);
      check("cntw.hold", 64'(bus.exception_cause), 64'h0B);
      tick(2);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
